// File: rtl/sbp_pkg.sv
// rtl/sbp_pkg.sv - shared widths, constants and update request type for the lookup ingress
package sbp_pkg;
  localparam int ADDR_BITS      = 32;
  localparam int LEN_BITS       = 6;
  localparam int MAX_PREFIX_LEN = 32;
  localparam int STAGE_ID_BITS  = 6;
  localparam int LOCATION_BITS  = 11;
  // pad2+stage6, pad1+loc11, pad2+lr2
  localparam int RESULT_BITS    = 24;
  localparam int ROOT_STAGE_ID  = 1;
  localparam int STAGE_ID_IDLE  = 0;
  localparam int CREDITS        = 8;
  localparam int UPD_FIFO_DEPTH = 4;
  localparam int MAX_UPD_BURST  = 4;

  typedef struct packed {
    logic [ADDR_BITS-1:0]     prefix;
    logic [LEN_BITS-1:0]      len;
    logic [STAGE_ID_BITS-1:0] stage_id;
    logic [LOCATION_BITS-1:0] location;
    logic [RESULT_BITS-1:0]   result;
  } upd_req_t;
endpackage

// File: rtl/sbp_lookup_ingress_if.sv
// rtl/sbp_lookup_ingress_if.sv - request, credit and token signals of the lookup ingress
// Lookup request (lkp_valid_i/lkp_ready_o/lkp_addr_i), update request (upd_*),
// credit return, issued token (valid_o..result_o), credits_o and sticky err_o.
// slave: the ingress block; master: the requester / pipeline side.
interface sbp_lookup_ingress_if import sbp_pkg::*; #(
  parameter int CREDITS = sbp_pkg::CREDITS
);
  logic                          lkp_valid_i;
  logic                          lkp_ready_o;
  logic [ADDR_BITS-1:0]          lkp_addr_i;
  logic                          upd_valid_i;
  logic                          upd_ready_o;
  logic [ADDR_BITS-1:0]          upd_prefix_i;
  logic [LEN_BITS-1:0]           upd_len_i;
  logic [STAGE_ID_BITS-1:0]      upd_stage_id_i;
  logic [LOCATION_BITS-1:0]      upd_location_i;
  logic [RESULT_BITS-1:0]        upd_result_i;
  logic                          credit_ret_i;
  logic                          valid_o;
  logic                          update_o;
  logic [ADDR_BITS-1:0]          ip_addr_o;
  logic [LEN_BITS-1:0]           bit_pos_o;
  logic [STAGE_ID_BITS-1:0]      stage_id_o;
  logic [LOCATION_BITS-1:0]      location_o;
  logic [RESULT_BITS-1:0]        result_o;
  logic [$clog2(CREDITS+1)-1:0]  credits_o;
  logic                          err_o;

  modport slave (
    input  lkp_valid_i, lkp_addr_i, upd_valid_i, upd_prefix_i, upd_len_i,
           upd_stage_id_i, upd_location_i, upd_result_i, credit_ret_i,
    output lkp_ready_o, upd_ready_o, valid_o, update_o, ip_addr_o, bit_pos_o,
           stage_id_o, location_o, result_o, credits_o, err_o
  );

  modport master (
    output lkp_valid_i, lkp_addr_i, upd_valid_i, upd_prefix_i, upd_len_i,
           upd_stage_id_i, upd_location_i, upd_result_i, credit_ret_i,
    input  lkp_ready_o, upd_ready_o, valid_o, update_o, ip_addr_o, bit_pos_o,
           stage_id_o, location_o, result_o, credits_o, err_o
  );
endinterface

// File: rtl/sbp_sync_fifo.sv
// rtl/sbp_sync_fifo.sv - single-clock FIFO of type T with full/empty flags
// Ports: clk, rst (async, active-low), push/push_data, pop/pop_data (head, valid when !empty), full, empty.
// DEPTH must be a power of 2, at least 2. Push while full is taken only with a pop in the
// same cycle; pop while empty is ignored, so a push into an empty FIFO is never bypassed.
module sbp_sync_fifo #(
  parameter type T     = logic,
  parameter int  DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output T     pop_data,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);

  T             mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (do_pop && !do_push) count <= count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/sbp_lookup_ingress.sv
// rtl/sbp_lookup_ingress.sv - arbitrates lookups and table updates into one pipeline token per cycle
// Ports: clk, rst (async, active-low), bus (sbp_lookup_ingress_if.slave): lookup and update
// requests in, credit returns in, registered token out, credits_o and sticky err_o out.
module sbp_lookup_ingress import sbp_pkg::*; #(
  parameter int ROOT_STAGE_ID  = sbp_pkg::ROOT_STAGE_ID,
  parameter int CREDITS        = sbp_pkg::CREDITS,
  parameter int UPD_FIFO_DEPTH = sbp_pkg::UPD_FIFO_DEPTH,
  parameter int MAX_UPD_BURST  = sbp_pkg::MAX_UPD_BURST
) (
  input logic                 clk,
  input logic                 rst,
  sbp_lookup_ingress_if.slave bus
);
  localparam int CW = $clog2(CREDITS + 1);
  localparam int BW = $clog2(MAX_UPD_BURST + 1);

  typedef struct packed {
    logic                     valid;
    logic                     update;
    logic [ADDR_BITS-1:0]     ip_addr;
    logic [LEN_BITS-1:0]      bit_pos;
    logic [STAGE_ID_BITS-1:0] stage_id;
    logic [LOCATION_BITS-1:0] location;
    logic [RESULT_BITS-1:0]   result;
  } token_t;

  upd_req_t      upd_req;
  upd_req_t      fifo_head;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic          upd_accept, upd_len_bad;
  logic          lkp_eligible, lkp_win, upd_win;
  logic          credit_ovf;
  logic [CW-1:0] credits;
  logic [BW-1:0] burst_cnt;
  logic          err;
  token_t        tok_d, tok_q;

  assign upd_req = '{prefix:   bus.upd_prefix_i,
                     len:      bus.upd_len_i,
                     stage_id: bus.upd_stage_id_i,
                     location: bus.upd_location_i,
                     result:   bus.upd_result_i};

  // Over-long prefixes are still handshaken so the requester never stalls on them.
  assign upd_len_bad     = bus.upd_len_i > LEN_BITS'(MAX_PREFIX_LEN);
  assign upd_accept      = bus.upd_valid_i && !fifo_full;
  assign fifo_push       = upd_accept && !upd_len_bad;
  assign bus.upd_ready_o = !fifo_full;

  sbp_sync_fifo #(.T(upd_req_t), .DEPTH(UPD_FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (upd_req),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Updates have priority, but a waiting lookup gets through after MAX_UPD_BURST updates.
  assign lkp_eligible    = bus.lkp_valid_i && (credits != '0);
  assign lkp_win         = lkp_eligible && (fifo_empty || burst_cnt == BW'(MAX_UPD_BURST));
  assign upd_win         = !fifo_empty && !lkp_win;
  assign fifo_pop        = upd_win;
  assign bus.lkp_ready_o = lkp_win;

  assign credit_ovf = bus.credit_ret_i && !lkp_win && (credits == CW'(CREDITS));

  always_comb begin
    tok_d = '0;
    if (lkp_win) begin
      tok_d.valid    = 1'b1;
      tok_d.ip_addr  = bus.lkp_addr_i;
      tok_d.stage_id = STAGE_ID_BITS'(ROOT_STAGE_ID);
    end else if (upd_win) begin
      tok_d.valid    = 1'b1;
      tok_d.update   = 1'b1;
      tok_d.ip_addr  = fifo_head.prefix;
      tok_d.bit_pos  = fifo_head.len;
      tok_d.stage_id = fifo_head.stage_id;
      tok_d.location = fifo_head.location;
      tok_d.result   = fifo_head.result;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tok_q     <= '0;
      credits   <= CW'(CREDITS);
      burst_cnt <= '0;
      err       <= 1'b0;
    end else begin
      tok_q <= tok_d;

      // Burst only counts updates that actually held a lookup back.
      if (lkp_win)                    burst_cnt <= '0;
      else if (upd_win && lkp_eligible) burst_cnt <= burst_cnt + BW'(1);

      if (lkp_win && !bus.credit_ret_i)                  credits <= credits - CW'(1);
      else if (!lkp_win && bus.credit_ret_i && !credit_ovf) credits <= credits + CW'(1);

      if (credit_ovf || (upd_accept && upd_len_bad)) err <= 1'b1;
    end
  end

  assign bus.valid_o    = tok_q.valid;
  assign bus.update_o   = tok_q.update;
  assign bus.ip_addr_o  = tok_q.ip_addr;
  assign bus.bit_pos_o  = tok_q.bit_pos;
  assign bus.stage_id_o = tok_q.stage_id;
  assign bus.location_o = tok_q.location;
  assign bus.result_o   = tok_q.result;
  assign bus.credits_o  = credits;
  assign bus.err_o      = err;
endmodule
